// File: rtl/noc_pkg.sv
// noc_pkg: shared NoC switch defaults and a pointer-width helper.
package noc_pkg;
  localparam int DATA_WIDTH_DEF = 32;
  localparam int FIFO_DEPTH_DEF = 4;
  function automatic int clog2_min1(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction
endpackage

// File: rtl/mux_2x1_out_fifo_if.sv
// mux_2x1_out_fifo_if: upstream write side and downstream valid/ready side of the mux output FIFO; MUX_2X1_OUT_FIFO_ALMOST_FULL_EN adds o_almost_full.
interface mux_2x1_out_fifo_if #(parameter int DATA_WIDTH = 32);
  logic                  i_valid;
  logic [DATA_WIDTH-1:0] i_data_bus;
  logic                  o_full;
  logic                  o_overflow;
  logic                  o_valid;
  logic [DATA_WIDTH-1:0] o_data_bus;
  logic                  i_ready;
`ifdef MUX_2X1_OUT_FIFO_ALMOST_FULL_EN
  logic                  o_almost_full;
  modport slave (input i_valid, i_data_bus, i_ready, output o_full, o_overflow, o_valid, o_data_bus, o_almost_full);
  modport master (output i_valid, i_data_bus, i_ready, input o_full, o_overflow, o_valid, o_data_bus, o_almost_full);
`else
  modport slave (input i_valid, i_data_bus, i_ready, output o_full, o_overflow, o_valid, o_data_bus);
  modport master (output i_valid, i_data_bus, i_ready, input o_full, o_overflow, o_valid, o_data_bus);
`endif
endinterface

// File: rtl/reg_array_1w1r.sv
// reg_array_1w1r: register storage with one synchronous write port, one combinational read port and synchronous clear.
module reg_array_1w1r #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 4,
  parameter int AW    = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             we_i,
  input  logic [AW-1:0]    waddr_i,
  input  logic [WIDTH-1:0] wdata_i,
  input  logic [AW-1:0]    raddr_i,
  output logic [WIDTH-1:0] rdata_o
);
  logic [WIDTH-1:0] mem_q [DEPTH];
  always_ff @(posedge clk) begin
    if (rst) mem_q <= '{default: '0};
    else if (we_i) mem_q[waddr_i] <= wdata_i;
  end
  assign rdata_o = mem_q[raddr_i];
endmodule

// File: rtl/mux_2x1_out_fifo.sv
// mux_2x1_out_fifo: registered FIFO between the NoC 2x1 mux and the next hop; MUX_2X1_OUT_FIFO_ALMOST_FULL_EN adds a registered almost-full flag.
module mux_2x1_out_fifo
  import noc_pkg::*;
#(
  parameter int DATA_WIDTH = DATA_WIDTH_DEF,
  parameter int FIFO_DEPTH = FIFO_DEPTH_DEF
) (
  input logic                clk,
  input logic                rst,
  mux_2x1_out_fifo_if.slave  bus
);
  localparam int PTR_WIDTH = clog2_min1(FIFO_DEPTH);
  localparam logic [PTR_WIDTH:0] FULL_CNT = (PTR_WIDTH+1)'(FIFO_DEPTH);
  logic [PTR_WIDTH-1:0]  wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [PTR_WIDTH:0]    count_q, count_d;
  logic                  overflow_q, overflow_d;
  logic                  valid, full, push, pop;
  logic [DATA_WIDTH-1:0] rd_data;
  assign valid = count_q != '0;
  assign full  = count_q == FULL_CNT;
  always_comb begin
    pop        = valid & bus.i_ready;
    push       = bus.i_valid & (~full | pop);
    wr_ptr_d   = push ? wr_ptr_q + 1'b1 : wr_ptr_q;
    rd_ptr_d   = pop ? rd_ptr_q + 1'b1 : rd_ptr_q;
    count_d    = (push & ~pop) ? count_q + 1'b1 : (pop & ~push) ? count_q - 1'b1 : count_q;
    overflow_d = overflow_q | (bus.i_valid & full & ~pop);
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      overflow_q <= 1'b0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      overflow_q <= overflow_d;
    end
  end
  reg_array_1w1r #(.WIDTH(DATA_WIDTH), .DEPTH(FIFO_DEPTH), .AW(PTR_WIDTH)) u_mem (
    .clk     (clk),
    .rst     (rst),
    .we_i    (push),
    .waddr_i (wr_ptr_q),
    .wdata_i (bus.i_data_bus),
    .raddr_i (rd_ptr_q),
    .rdata_o (rd_data)
  );
  assign bus.o_valid    = valid;
  assign bus.o_full     = full;
  assign bus.o_overflow = overflow_q;
  assign bus.o_data_bus = valid ? rd_data : '0;
`ifdef MUX_2X1_OUT_FIFO_ALMOST_FULL_EN
  // Registered from next-state count so it lines up with o_full in the same cycle
  localparam logic [PTR_WIDTH:0] AF_CNT = (PTR_WIDTH+1)'(FIFO_DEPTH-1);
  logic almost_full_q;
  always_ff @(posedge clk) begin
    if (rst) almost_full_q <= 1'b0;
    else almost_full_q <= count_d >= AF_CNT;
  end
  assign bus.o_almost_full = almost_full_q;
`endif
endmodule
